// File: rtl/lcd12864_frame_writer_if.sv
// ST7920 8-bit parallel write bus between the frame writer (master) and the panel (slave).
interface lcd12864_frame_writer_if;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_psb;
  logic       lcd_en;
  logic [7:0] lcd_db;

  modport master (output lcd_rs, lcd_rw, lcd_psb, lcd_en, lcd_db);
  modport slave  (input  lcd_rs, lcd_rw, lcd_psb, lcd_en, lcd_db);
endinterface

// File: rtl/lcd12864_frame_writer.sv
// Write-only ST7920 (QC12864B) controller: power-on wait, fixed init sequence, then streams a
// LINES x COLS text frame from an external char buffer into DDRAM on request or periodically.
module lcd12864_frame_writer #(
  parameter int unsigned  LINES     = 4,
  parameter int unsigned  COLS      = 16,
  parameter int unsigned  SETUP_CYC = 2,
  parameter int unsigned  EN_CYC    = 25,
  parameter int unsigned  EXEC_CYC  = 3600,
  parameter int unsigned  CLR_CYC   = 80000,
  parameter int unsigned  POR_CYC   = 2000000,
  parameter int unsigned  AUTO_CYC  = 0,
  localparam int unsigned AW        = $clog2(LINES * COLS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic [AW-1:0]           ch_addr,
  input  logic [7:0]              ch_data,
  output logic                    busy,
  output logic                    init_done,
  output logic                    frame_done,
  lcd12864_frame_writer_if.master lcd
);

  localparam int unsigned LW = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int unsigned CW = $clog2(COLS);

  typedef enum logic [2:0] {StPor, StInit, StIdle, StAddr, StFetch, StData} state_e;

  state_e        state_q, state_d;
  logic [20:0]   cnt_q, cnt_d;
  logic          xfer_q, xfer_d;
  logic          rs_q, rs_d;
  logic [7:0]    db_q, db_d;
  logic          en_q, en_d;
  logic [2:0]    idx_q, idx_d;
  logic [LW-1:0] line_q, line_d;
  logic [CW-1:0] col_q, col_d;
  logic          pend_q, pend_d;
  logic          init_done_q, init_done_d;
  logic          frame_done_q, frame_done_d;

  logic [20:0]   period;
  logic          xfer_end;
  logic          send, send_rs;
  logic [7:0]    send_db;

  function automatic logic [7:0] init_cmd(input logic [2:0] i);
    case (i)
      3'd0:    init_cmd = 8'h30;
      3'd1:    init_cmd = 8'h30;
      3'd2:    init_cmd = 8'h0C;
      3'd3:    init_cmd = 8'h01;
      default: init_cmd = 8'h06;
    endcase
  endfunction

  // DDRAM rows are interleaved: line 2 continues line 0, line 3 continues line 1.
  function automatic logic [7:0] line_base(input logic [LW-1:0] l);
    case (2'(l))
      2'd0:    line_base = 8'h80;
      2'd1:    line_base = 8'h90;
      2'd2:    line_base = 8'h88;
      default: line_base = 8'h98;
    endcase
  endfunction

  always_comb begin
    period   = (!rs_q && db_q == 8'h01) ? 21'(CLR_CYC) : 21'(EXEC_CYC);
    xfer_end = xfer_q && (cnt_q == period - 21'd1);

    state_d      = state_q;
    cnt_d        = xfer_q ? cnt_q + 21'd1 : cnt_q;
    xfer_d       = xfer_end ? 1'b0 : xfer_q;
    rs_d         = rs_q;
    db_d         = db_q;
    idx_d        = idx_q;
    line_d       = line_q;
    col_d        = col_q;
    pend_d       = pend_q | (start && state_q != StIdle);
    init_done_d  = init_done_q;
    frame_done_d = 1'b0;
    send         = 1'b0;
    send_rs      = 1'b0;
    send_db      = 8'h00;

    unique case (state_q)
      StPor: begin
        cnt_d = cnt_q + 21'd1;
        if (cnt_q == 21'(POR_CYC - 1)) begin
          state_d = StInit;
          idx_d   = 3'd0;
          send    = 1'b1;
          send_db = init_cmd(3'd0);
        end
      end
      StInit: begin
        if (xfer_end) begin
          if (idx_q == 3'd4) begin
            init_done_d = 1'b1;
            state_d     = StIdle;
            cnt_d       = '0;
          end else begin
            idx_d   = idx_q + 3'd1;
            send    = 1'b1;
            send_db = init_cmd(idx_q + 3'd1);
          end
        end
      end
      StIdle: begin
        if (start || pend_q || (AUTO_CYC > 0 && cnt_q == 21'(AUTO_CYC))) begin
          state_d = StAddr;
          line_d  = '0;
          pend_d  = 1'b0;
        end else if (AUTO_CYC > 0) begin
          cnt_d = cnt_q + 21'd1;
        end
      end
      StAddr: begin
        if (!xfer_q) begin
          col_d   = '0;
          send    = 1'b1;
          send_db = line_base(line_q);
        end else if (xfer_end) begin
          state_d = StFetch;
        end
      end
      StFetch: state_d = StData;
      StData: begin
        if (!xfer_q) begin
          send    = 1'b1;
          send_rs = 1'b1;
          send_db = ch_data;
        end else if (xfer_end) begin
          if (col_q != CW'(COLS - 1)) begin
            col_d   = col_q + 1'b1;
            state_d = StFetch;
          end else if (line_q != LW'(LINES - 1)) begin
            line_d  = line_q + 1'b1;
            state_d = StAddr;
          end else begin
            frame_done_d = 1'b1;
            state_d      = StIdle;
            cnt_d        = '0;
          end
        end
      end
      default: state_d = StPor;
    endcase

    if (send) begin
      xfer_d = 1'b1;
      cnt_d  = '0;
      rs_d   = send_rs;
      db_d   = send_db;
    end

    en_d = xfer_d && (cnt_d >= 21'(SETUP_CYC)) && (cnt_d < 21'(SETUP_CYC + EN_CYC));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StPor;
      cnt_q        <= '0;
      xfer_q       <= 1'b0;
      rs_q         <= 1'b0;
      db_q         <= 8'h00;
      en_q         <= 1'b0;
      idx_q        <= '0;
      line_q       <= '0;
      col_q        <= '0;
      pend_q       <= 1'b0;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      xfer_q       <= xfer_d;
      rs_q         <= rs_d;
      db_q         <= db_d;
      en_q         <= en_d;
      idx_q        <= idx_d;
      line_q       <= line_d;
      col_q        <= col_d;
      pend_q       <= pend_d;
      init_done_q  <= init_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ch_addr     = AW'(32'(line_q) * COLS + 32'(col_q));
  assign busy        = (state_q != StIdle);
  assign init_done   = init_done_q;
  assign frame_done  = frame_done_q;
  assign lcd.lcd_rs  = rs_q;
  assign lcd.lcd_rw  = 1'b0;
  assign lcd.lcd_psb = 1'b1;
  assign lcd.lcd_en  = en_q;
  assign lcd.lcd_db  = db_q;

endmodule

// File: tb/tb_lcd12864_frame_writer.sv
// Directed bench for lcd12864_frame_writer: three instances (4x16 on request, 2x4 on request,
// 2x4 auto refresh) with shortened panel timing; strobes are logged on EN falling edges.
module tb_lcd12864_frame_writer;

  localparam int SETUP = 2;
  localparam int ENC   = 5;
  localparam int EXEC  = 40;
  localparam int CLR   = 100;
  localparam int POR   = 200;
  localparam int INIT_END = POR + 4 * EXEC + CLR;  // 460

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_bc;
  logic start_a, start_b, start_c;
  logic [5:0] addr_a;
  logic [2:0] addr_b, addr_c;
  logic [7:0] data_a, data_b, data_c;
  logic busy_a, busy_b, busy_c;
  logic idone_a, idone_b, idone_c;
  logic fdone_a, fdone_b, fdone_c;

  lcd12864_frame_writer_if if_a ();
  lcd12864_frame_writer_if if_b ();
  lcd12864_frame_writer_if if_c ();

  lcd12864_frame_writer #(
    .LINES(4), .COLS(16), .SETUP_CYC(SETUP), .EN_CYC(ENC), .EXEC_CYC(EXEC),
    .CLR_CYC(CLR), .POR_CYC(POR), .AUTO_CYC(0)
  ) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .ch_addr(addr_a), .ch_data(data_a),
    .busy(busy_a), .init_done(idone_a), .frame_done(fdone_a), .lcd(if_a)
  );

  lcd12864_frame_writer #(
    .LINES(2), .COLS(4), .SETUP_CYC(SETUP), .EN_CYC(ENC), .EXEC_CYC(EXEC),
    .CLR_CYC(CLR), .POR_CYC(POR), .AUTO_CYC(0)
  ) dut_b (
    .clk(clk), .rst(rst_bc), .start(start_b), .ch_addr(addr_b), .ch_data(data_b),
    .busy(busy_b), .init_done(idone_b), .frame_done(fdone_b), .lcd(if_b)
  );

  lcd12864_frame_writer #(
    .LINES(2), .COLS(4), .SETUP_CYC(SETUP), .EN_CYC(ENC), .EXEC_CYC(EXEC),
    .CLR_CYC(CLR), .POR_CYC(POR), .AUTO_CYC(100)
  ) dut_c (
    .clk(clk), .rst(rst_bc), .start(start_c), .ch_addr(addr_c), .ch_data(data_c),
    .busy(busy_c), .init_done(idone_c), .frame_done(fdone_c), .lcd(if_c)
  );

  // Char buffers hold k at address k, one-cycle read latency.
  always @(posedge clk) begin
    data_a <= 8'(addr_a);
    data_b <= 8'(addr_b);
    data_c <= 8'(addr_c);
  end

  int cyc_a = 0, cyc_bc = 0;
  always @(posedge clk) begin
    cyc_a  <= rst_a  ? 0 : cyc_a + 1;
    cyc_bc <= rst_bc ? 0 : cyc_bc + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [8:0] log_a[$], log_b[$], log_c[$];
  int rise_a[$], rise_b[$], rise_c[$];
  int fd_a[$], fd_b[$], fd_c[$];

  bit         skip_a = 1'b0;
  logic       en_prev_a = 1'b0, en_prev_b = 1'b0, en_prev_c = 1'b0;
  logic [8:0] bus_prev_a = '0;
  int         stab_a = 0, hi_a = 0;

  always @(negedge clk) begin
    logic [8:0] bus;
    bus = {if_a.lcd_rs, if_a.lcd_db};
    if (bus == bus_prev_a) stab_a++;
    else stab_a = 0;
    if (!skip_a) begin
      if (if_a.lcd_en && !en_prev_a) begin
        rise_a.push_back(cyc_a);
        hi_a = 0;
        check("t6_setup", 32'(stab_a >= SETUP), 32'd1);
      end
      if (if_a.lcd_en) hi_a++;
      if (!if_a.lcd_en && en_prev_a) begin
        log_a.push_back(bus);
        check("t6_en_width", 32'(hi_a), 32'(ENC));
        check("t6_hold", 32'(stab_a >= SETUP + ENC), 32'd1);
      end
      if (fdone_a) fd_a.push_back(cyc_a);
    end
    bus_prev_a = bus;
    en_prev_a  = if_a.lcd_en;
  end

  always @(negedge clk) begin
    if (if_b.lcd_en && !en_prev_b) rise_b.push_back(cyc_bc);
    if (!if_b.lcd_en && en_prev_b) log_b.push_back({if_b.lcd_rs, if_b.lcd_db});
    if (fdone_b) fd_b.push_back(cyc_bc);
    en_prev_b = if_b.lcd_en;
    if (if_c.lcd_en && !en_prev_c) rise_c.push_back(cyc_bc);
    if (!if_c.lcd_en && en_prev_c) log_c.push_back({if_c.lcd_rs, if_c.lcd_db});
    if (fdone_c) fd_c.push_back(cyc_bc);
    en_prev_c = if_c.lcd_en;
  end

  function automatic logic [31:0] get_log(input int which, input int idx);
    get_log = 'x;
    case (which)
      0: if (idx < log_a.size()) get_log = 32'(log_a[idx]);
      1: if (idx < log_b.size()) get_log = 32'(log_b[idx]);
      default: if (idx < log_c.size()) get_log = 32'(log_c[idx]);
    endcase
  endfunction

  function automatic logic [31:0] get_rise(input int which, input int idx);
    get_rise = 'x;
    case (which)
      0: if (idx < rise_a.size()) get_rise = 32'(rise_a[idx]);
      1: if (idx < rise_b.size()) get_rise = 32'(rise_b[idx]);
      default: if (idx < rise_c.size()) get_rise = 32'(rise_c[idx]);
    endcase
  endfunction

  function automatic logic [31:0] get_fd(input int which, input int idx);
    get_fd = 'x;
    case (which)
      0: if (idx < fd_a.size()) get_fd = 32'(fd_a[idx]);
      1: if (idx < fd_b.size()) get_fd = 32'(fd_b[idx]);
      default: if (idx < fd_c.size()) get_fd = 32'(fd_c[idx]);
    endcase
  endfunction

  function automatic logic [8:0] init_byte(input int k);
    case (k)
      0, 1:    init_byte = 9'h030;
      2:       init_byte = 9'h00C;
      3:       init_byte = 9'h001;
      default: init_byte = 9'h006;
    endcase
  endfunction

  // k-th strobe of a frame: each line is one address instruction then cols data bytes.
  function automatic logic [8:0] frame_byte(input int cols, input int k);
    int l, c;
    l = k / (cols + 1);
    c = k % (cols + 1);
    if (c == 0) begin
      case (l)
        0:       frame_byte = 9'h080;
        1:       frame_byte = 9'h090;
        2:       frame_byte = 9'h088;
        default: frame_byte = 9'h098;
      endcase
    end else begin
      frame_byte = {1'b1, 8'(l * cols + c - 1)};
    end
  endfunction

  task automatic check_init(input string tag, input int which, input int first);
    for (int k = 0; k < 5; k++)
      check($sformatf("%s[%0d]", tag, k), get_log(which, first + k), 32'(init_byte(k)));
  endtask

  task automatic check_frame(input string tag, input int which, input int first,
                             input int lines, input int cols);
    for (int k = 0; k < lines * (cols + 1); k++)
      check($sformatf("%s[%0d]", tag, k), get_log(which, first + k), 32'(frame_byte(cols, k)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_a = 1'b1; rst_bc = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // T1 reset state
    check("rst_en", 32'(if_a.lcd_en), 32'd0);
    check("rst_rs", 32'(if_a.lcd_rs), 32'd0);
    check("rst_db", 32'(if_a.lcd_db), 32'h00);
    check("rst_rw", 32'(if_a.lcd_rw), 32'd0);
    check("rst_psb", 32'(if_a.lcd_psb), 32'd1);
    check("rst_addr", 32'(addr_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd1);
    check("rst_init_done", 32'(idone_a), 32'd0);
    check("rst_frame_done", 32'(fdone_a), 32'd0);
    @(negedge clk);
    rst_a = 1'b0; rst_bc = 1'b0;

    // T3: request during INIT on dut_b
    while (cyc_bc < 300) @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;

    // T1: init sequence and timing
    n = 0;
    while (!idone_a && n < 2000) begin @(negedge clk); n++; end
    check("t1_init_done_cyc", 32'(cyc_a), 32'(INIT_END));
    check("t1_idle_busy", 32'(busy_a), 32'd0);
    check("t1_strobes", 32'(log_a.size()), 32'd5);
    check_init("t1_init", 0, 0);
    check("t1_first_rise", get_rise(0, 0), 32'(POR + SETUP));

    // T2: full 4x16 frame
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("t2_busy", 32'(busy_a), 32'd1);
    while (cyc_bc < 600) @(negedge clk);
    start_b = 1'b1;
    repeat (20) @(negedge clk);
    start_b = 1'b0;
    n = 0;
    while (fd_a.size() == 0 && n < 5000) begin @(negedge clk); n++; end
    repeat (50) @(negedge clk);
    check("t2_frame_done_count", 32'(fd_a.size()), 32'd1);
    check("t2_strobes", 32'(log_a.size()), 32'd73);
    check_frame("t2_frame", 0, 5, 4, 16);
    check("t2_fd_after_last", get_fd(0, 0) - get_rise(0, 72), 32'(EXEC - SETUP));

    // T4: reset while EN is high mid-frame
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    n = 0;
    while (log_a.size() < 83 && n < 1000) begin @(negedge clk); n++; end
    n = 0;
    while (!if_a.lcd_en && n < 200) begin @(negedge clk); n++; end
    check("t4_en_before_rst", 32'(if_a.lcd_en), 32'd1);
    skip_a = 1'b1;
    rst_a  = 1'b1;
    @(posedge clk);
    #1;
    check("t4_en_after_rst", 32'(if_a.lcd_en), 32'd0);
    check("t4_busy_after_rst", 32'(busy_a), 32'd1);
    check("t4_init_done_after_rst", 32'(idone_a), 32'd0);
    @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    log_a.delete(); rise_a.delete(); fd_a.delete();
    skip_a = 1'b0;
    n = 0;
    while (!idone_a && n < 2000) begin @(negedge clk); n++; end
    check("t4_init_done_cyc", 32'(cyc_a), 32'(INIT_END));
    check("t4_strobes", 32'(log_a.size()), 32'd5);
    check_init("t4_init", 0, 0);
    check("t4_first_rise", get_rise(0, 0), 32'(POR + SETUP));
    check("t4_no_frame_done", 32'(fd_a.size()), 32'd0);

    // T3: pending frame right after init, then exactly one more frame
    check("t3_strobes", 32'(log_b.size()), 32'd25);
    check_init("t3_init", 1, 0);
    check_frame("t3_f1", 1, 5, 2, 4);
    check_frame("t3_f2", 1, 15, 2, 4);
    check("t3_frame_done_count", 32'(fd_b.size()), 32'd2);
    check("t3_first_rise", get_rise(1, 5), 32'(INIT_END + 2 + SETUP));
    check("t3_back_to_back", get_rise(1, 15) - get_fd(1, 0), 32'(2 + SETUP));

    // T5: auto refresh every AUTO_CYC idle cycles
    n = 0;
    while (fd_c.size() < 3 && n < 3000) begin @(negedge clk); n++; end
    check("t5_first_rise", get_rise(2, 5), 32'(INIT_END + 100 + 2 + SETUP));
    for (int i = 0; i < 2; i++)
      check($sformatf("t5_gap%0d", i), get_rise(2, 5 + 10 * (i + 1)) - get_fd(2, i),
            32'(100 + 2 + SETUP));
    check_frame("t5_f1", 2, 5, 2, 4);
    check_frame("t5_f2", 2, 15, 2, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
